// File: rtl/vc_read_scheduler_if.sv
// Scheduler <-> VC buffer / downstream link bundle.
// master = scheduler side, slave = buffer/link side.
interface vc_read_scheduler_if #(
    parameter int VC_NUM_PER_PORT = 4,
    parameter int PYLD_WIDTH      = 32,
    parameter int FLIT_TYPE_WIDTH = 2
);
    localparam int FLIT_WIDTH = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT;

    logic [VC_NUM_PER_PORT-1:0] vc_not_empty;
    logic                       rd_en;
    logic [VC_NUM_PER_PORT-1:0] vc_num_rd;
    logic [FLIT_WIDTH-1:0]      fifo_dout;
    logic [VC_NUM_PER_PORT-1:0] credit_in;
    logic [FLIT_WIDTH-1:0]      flit_out;
    logic                       flit_out_wr;
    logic [VC_NUM_PER_PORT-1:0] vc_credit_avail;

    modport master (
        input  vc_not_empty, fifo_dout, credit_in,
        output rd_en, vc_num_rd, flit_out, flit_out_wr, vc_credit_avail
    );

    modport slave (
        output vc_not_empty, fifo_dout, credit_in,
        input  rd_en, vc_num_rd, flit_out, flit_out_wr, vc_credit_avail
    );
endinterface

// File: rtl/vc_read_scheduler.sv
// Credit-gated, packet-locked round-robin reader of per-VC flit buffers.
// Latency: rd_en is combinational; flit_out/flit_out_wr follow one cycle later with buffer data.
// Backpressure: a VC is read only with nonzero credit; a locked VC stalls in place until refilled.
module vc_read_scheduler #(
    parameter int VC_NUM_PER_PORT = 4,
    parameter int PYLD_WIDTH      = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int CREDIT_NUM      = 4
) (
    input logic                 clk,
    input logic                 reset,
    vc_read_scheduler_if.master bus
);
    localparam int FLIT_WIDTH = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_NUM_PER_PORT;
    localparam int N          = VC_NUM_PER_PORT;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam int CRD_W      = $clog2(CREDIT_NUM) + 1;

    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEAD   = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_TAIL   = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_SINGLE = FLIT_TYPE_WIDTH'(3);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    typedef struct packed {
        logic [FLIT_TYPE_WIDTH-1:0] ftype;
        logic [N-1:0]               vc;
        logic [PYLD_WIDTH-1:0]      pyld;
    } flit_t;

    state_t                  state, state_nxt;
    logic [N-1:0]            lock_vc;
    logic [IDX_W-1:0]        rr_last;
    logic [CRD_W-1:0]        credit [N];
    logic                    rd_valid;
    logic [N-1:0]            rd_vc;
    logic                    mid_pkt;

    logic [N-1:0]            eligible;
    logic [N-1:0]            credit_avail;
    logic                    any_elig;
    logic [IDX_W-1:0]        grant_idx;
    logic [N-1:0]            grant_oh;
    logic                    lock_rd;
    logic                    rd_int;
    logic [N-1:0]            vc_rd_int;
    logic [FLIT_TYPE_WIDTH-1:0] in_type;
    logic [PYLD_WIDTH-1:0]   in_pyld;
    logic                    in_last;
    flit_t                   out_flit;

    assign in_type = bus.fifo_dout[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    assign in_pyld = bus.fifo_dout[PYLD_WIDTH-1:0];
    assign in_last = (in_type == FT_TAIL) || (in_type == FT_SINGLE);

    always_comb begin
        eligible     = '0;
        credit_avail = '0;
        for (int i = 0; i < N; i++) begin
            credit_avail[i] = (credit[i] != '0);
            eligible[i]     = bus.vc_not_empty[i] && credit_avail[i];
        end
    end

    // Search starts one past the last IDLE grant and wraps modulo N.
    always_comb begin
        logic [IDX_W:0] cand;
        cand      = '0;
        grant_idx = '0;
        any_elig  = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand = {1'b0, rr_last} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N))
                cand = cand - (IDX_W+1)'(N);
            if (!any_elig && eligible[cand[IDX_W-1:0]]) begin
                any_elig  = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_oh = any_elig ? (N'(1) << grant_idx) : '0;
    assign lock_rd  = |(eligible & lock_vc);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A last flit returning while the locked VC is read again means that read is the next head.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig) state_nxt = LOCKED;
            LOCKED:  if (rd_valid && in_last && !lock_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_int    = 1'b0;
        vc_rd_int = '0;
        case (state)
            IDLE: if (any_elig) begin
                rd_int    = 1'b1;
                vc_rd_int = grant_oh;
            end
            LOCKED: if (lock_rd) begin
                rd_int    = 1'b1;
                vc_rd_int = lock_vc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                credit[i] <= CRD_W'(CREDIT_NUM);
            lock_vc  <= '0;
            rr_last  <= IDX_W'(N - 1);
            rd_valid <= 1'b0;
            rd_vc    <= '0;
            mid_pkt  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case ({bus.credit_in[i], vc_rd_int[i]})
                    2'b10:   credit[i] <= credit[i] + CRD_W'(1);
                    2'b01:   credit[i] <= credit[i] - CRD_W'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
            if (state == IDLE && any_elig) begin
                lock_vc <= grant_oh;
                rr_last <= grant_idx;
            end
            rd_valid <= rd_int;
            rd_vc    <= vc_rd_int;
            if (rd_valid)
                mid_pkt <= !in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++)
                assert (!(bus.credit_in[i] && !vc_rd_int[i] && credit[i] == CRD_W'(CREDIT_NUM)))
                    else $error("vc_read_scheduler: credit overflow on vc %0d", i);
            assert (!(rd_valid && state == LOCKED && mid_pkt && in_type == FT_HEAD))
                else $error("vc_read_scheduler: head flit returned mid-packet");
        end
    end

    assign out_flit.ftype = in_type;
    assign out_flit.vc    = rd_vc;
    assign out_flit.pyld  = in_pyld;

    assign bus.rd_en           = rd_int & ~reset;
    assign bus.vc_num_rd       = vc_rd_int & {N{~reset}};
    assign bus.flit_out_wr     = rd_valid & ~reset;
    assign bus.flit_out        = out_flit;
    assign bus.vc_credit_avail = credit_avail;
endmodule

// File: tb/tb_vc_read_scheduler.sv
// Bench for vc_read_scheduler: buffer model, per-cycle reference model, directed and random traffic.
module tb_vc_read_scheduler;
    localparam int N  = 4;
    localparam int PW = 32;
    localparam int TW = 2;
    localparam int CN = 4;
    localparam int FW = PW + TW + N;

    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_SING = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_read_scheduler_if #(.VC_NUM_PER_PORT(N), .PYLD_WIDTH(PW), .FLIT_TYPE_WIDTH(TW)) bus ();

    vc_read_scheduler #(
        .VC_NUM_PER_PORT(N), .PYLD_WIDTH(PW), .FLIT_TYPE_WIDTH(TW), .CREDIT_NUM(CN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // VC buffer contents, {type, payload} per flit
    logic [TW+PW-1:0] vcq [N][$];
    int               rem [N];

    // reference model state
    int               cred [N];
    bit               m_locked;
    int               m_lvc;
    int               m_start;
    bit               prev_rd;
    int               prev_vc;
    logic [TW+PW-1:0] prev_flit;

    logic             obs_rd, obs_wr;
    logic [N-1:0]     obs_oh;
    int               total = 0;
    int               bad   = 0;
    int               nrd;

    typedef struct {
        logic [N-1:0] ne;
        logic         exp_rd;
        logic [N-1:0] exp_oh;
    } vec_t;
    vec_t tbl [6];

    logic [N-1:0] exp35 [10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_last(input logic [1:0] t);
        return (t == T_TAIL) || (t == T_SING);
    endfunction

    function automatic void push(input int vc, input logic [1:0] t);
        logic [PW-1:0] p;
        p = $urandom;
        vcq[vc].push_back({t, p});
    endfunction

    function automatic void gen_flit(input int vc);
        int len;
        len = 0;
        if (rem[vc] == 0) begin
            len = $urandom_range(1, 4);
            if (len == 1) push(vc, T_SING);
            else begin
                push(vc, T_HEAD);
                rem[vc] = len - 1;
            end
        end else begin
            rem[vc]--;
            push(vc, (rem[vc] == 0) ? T_TAIL : T_BODY);
        end
    endfunction

    function automatic void clear_q();
        for (int i = 0; i < N; i++) begin
            vcq[i].delete();
            rem[i] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) cred[i] = CN;
        m_locked  = 1'b0;
        m_lvc     = 0;
        m_start   = 0;
        prev_rd   = 1'b0;
        prev_vc   = 0;
        prev_flit = '0;
    endfunction

    // Entered and left just after a falling edge.
    task automatic do_reset();
        reset            = 1'b1;
        bus.vc_not_empty = '1;
        bus.credit_in    = '0;
        bus.fifo_dout    = FW'({$urandom, $urandom});
        #1;
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_vc_num_rd", bus.vc_num_rd, 0);
        check("rst_flit_out_wr", bus.flit_out_wr, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_flit_out_wr_after", bus.flit_out_wr, 0);
        check("rst_credit_avail", bus.vc_credit_avail, 4'b1111);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [N-1:0] cin);
        logic [N-1:0]  ne, elig, e_oh, e_av, p_oh;
        logic [FW-1:0] e_flit;
        bit            erd;
        int            evc, j;
        ne = '0; elig = '0; e_av = '0;
        for (int i = 0; i < N; i++) begin
            ne[i]   = (vcq[i].size() != 0);
            e_av[i] = (cred[i] > 0);
            elig[i] = ne[i] && e_av[i];
        end
        bus.vc_not_empty = ne;
        bus.credit_in    = cin;
        if (prev_rd) bus.fifo_dout = {prev_flit[TW+PW-1:PW], N'($urandom), prev_flit[PW-1:0]};
        else         bus.fifo_dout = FW'({$urandom, $urandom});
        #1;
        erd = 1'b0;
        evc = 0;
        if (m_locked) begin
            erd = elig[m_lvc];
            evc = m_lvc;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_start + k) % N;
                if (!erd && elig[j]) begin
                    erd = 1'b1;
                    evc = j;
                end
            end
        end
        e_oh   = erd ? (N'(1) << evc) : '0;
        p_oh   = N'(1) << prev_vc;
        obs_rd = bus.rd_en;
        obs_oh = bus.vc_num_rd;
        obs_wr = bus.flit_out_wr;
        check("rd_en", bus.rd_en, erd);
        check("vc_num_rd", bus.vc_num_rd, e_oh);
        check("flit_out_wr", bus.flit_out_wr, prev_rd);
        if (prev_rd) begin
            e_flit = {prev_flit[TW+PW-1:PW], p_oh, prev_flit[PW-1:0]};
            check("flit_out", bus.flit_out, e_flit);
        end
        check("vc_credit_avail", bus.vc_credit_avail, e_av);
        if (!m_locked) begin
            if (erd) begin
                m_locked = 1'b1;
                m_lvc    = evc;
                m_start  = (evc + 1) % N;
            end
        end else if (prev_rd && is_last(prev_flit[TW+PW-1:PW]) && !erd) begin
            m_locked = 1'b0;
        end
        for (int i = 0; i < N; i++)
            cred[i] = cred[i] + int'(cin[i]) - ((erd && evc == i) ? 1 : 0);
        prev_rd = erd;
        if (erd) begin
            prev_vc   = evc;
            prev_flit = vcq[evc].pop_front();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] cin;
        bus.vc_not_empty = '0;
        bus.credit_in    = '0;
        bus.fifo_dout    = '0;
        clear_q();
        model_reset();

        tbl[0] = '{4'b0000, 1'b0, 4'b0000};
        tbl[1] = '{4'b0001, 1'b1, 4'b0001};
        tbl[2] = '{4'b0110, 1'b1, 4'b0010};
        tbl[3] = '{4'b1000, 1'b1, 4'b1000};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001};
        tbl[5] = '{4'b1100, 1'b1, 4'b0100};

        @(negedge clk);
        // post-reset grant priority, combinational in IDLE
        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.vc_not_empty = tbl[v].ne;
            bus.credit_in    = '0;
            #1;
            check("tbl_rd_en", bus.rd_en, tbl[v].exp_rd);
            check("tbl_vc_num_rd", bus.vc_num_rd, tbl[v].exp_oh);
        end

        // head/body/tail on VC2
        clear_q();
        do_reset();
        push(2, T_HEAD); push(2, T_BODY); push(2, T_TAIL);
        for (int c = 0; c < 6; c++) begin
            step('0);
            check("s1_vc_num_rd", obs_oh, (c < 3) ? 4'b0100 : 4'b0000);
            check("s1_flit_out_wr", obs_wr, (c >= 1 && c <= 3));
        end
        push(0, T_SING);
        step('0);
        check("s1_idle_after_tail", obs_oh, 4'b0001);

        // two VCs, then round-robin continues from VC2
        clear_q();
        do_reset();
        push(0, T_HEAD); push(0, T_TAIL); push(1, T_HEAD); push(1, T_TAIL);
        for (int c = 0; c < 10; c++) begin
            if (c == 6) begin
                push(0, T_SING);
                push(3, T_SING);
            end
            step('0);
            check("s2_vc_num_rd", obs_oh, exp35[c]);
        end

        // credit exhaustion stall on VC1
        clear_q();
        do_reset();
        push(1, T_HEAD);
        for (int k = 0; k < 4; k++) push(1, T_BODY);
        push(1, T_TAIL);
        nrd = 0;
        for (int c = 0; c < 8; c++) begin
            step('0);
            if (obs_rd) nrd++;
        end
        check("s3_reads_no_credit", nrd, 4);
        nrd = 0;
        step(4'b0010);
        if (obs_rd) nrd++;
        for (int c = 0; c < 4; c++) begin
            step('0);
            if (obs_rd) nrd++;
        end
        check("s3_reads_one_credit", nrd, 1);

        // back-to-back singles on VC3 keep the lock
        clear_q();
        do_reset();
        for (int k = 0; k < 5; k++) push(3, T_SING);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) push(0, T_SING);
            step((cred[3] < CN) ? 4'b1000 : 4'b0000);
            check("s4_vc_num_rd", obs_oh,
                  (c < 5) ? 4'b1000 : ((c == 6) ? 4'b0001 : 4'b0000));
        end

        // reset right after a head read on VC1
        clear_q();
        do_reset();
        push(1, T_HEAD); push(1, T_BODY); push(1, T_TAIL);
        step('0);
        check("s5_head_read", obs_oh, 4'b0010);
        do_reset();
        push(0, T_SING);
        push(1, T_HEAD); push(1, T_BODY); push(1, T_BODY);
        step('0);
        check("s5_first_grant", obs_oh, 4'b0001);
        check("s5_no_stale_wr", obs_wr, 0);
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            step('0);
            if (obs_oh[1]) nrd++;
        end
        check("s5_vc1_reads_full_credit", nrd, 4);

        // random traffic against the reference model
        clear_q();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && vcq[i].size() < 8) gen_flit(i);
            cin = '0;
            for (int i = 0; i < N; i++)
                if (cred[i] < CN && $urandom_range(0, 2) == 0) cin[i] = 1'b1;
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(cin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
